mac_result_drain: RTL

// - Read-side companion of the MAC row. Once a tile's accumulation ends, it waits for the
//   2-stage MAC pipeline to settle and snapshots every Cout into shadow registers.
// - In that same snapshot cycle it pulses Clr, so the row is immediately free for the next tile.
// - It then streams the snapshot out one word per handshake on a valid/ready port to the

---
 rtl/mac_pkg.sv | 12 +
 rtl/mac_result_drain_shadow_bank.sv | 40 ++++
 rtl/mac_result_drain.sv | 116 +++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared types and helpers for the MAC row result path.
package mac_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DRAIN} drain_state_t;

    localparam int DEFAULT_SETTLE_CYCLES = 2;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mac_result_drain_shadow_bank.sv
// Snapshot registers for every MAC Cout with an indexed read port.
module mac_shadow_bank
    import mac_pkg::*;
#(
    parameter int NUM_MAC   = 8,
    parameter int ACC_WIDTH = 24,
    parameter int IW        = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_i,
    input  logic [NUM_MAC*ACC_WIDTH-1:0] cout_i,
    input  logic [IW-1:0]                idx_i,
    output logic [ACC_WIDTH-1:0]         data_o
);

    logic [ACC_WIDTH-1:0] shadow_q [NUM_MAC];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_MAC; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (load_i) begin
            for (int i = 0; i < NUM_MAC; i++) begin
                shadow_q[i] <= cout_i[i*ACC_WIDTH +: ACC_WIDTH];
            end
        end
    end

    always_comb begin
        data_o = '0;
        for (int i = 0; i < NUM_MAC; i++) begin
            if (idx_i == IW'(i)) begin
                data_o = shadow_q[i];
            end
        end
    end

endmodule

// File: rtl/mac_result_drain.sv
// Waits for the MAC pipeline to settle, snapshots and clears the row,
// then streams the snapshot out over a valid/ready port.
module mac_result_drain
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ACC_WIDTH     = DATA_WIDTH*3,
    parameter int NUM_MAC       = 8,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [NUM_MAC*ACC_WIDTH-1:0]      mac_cout,
    output logic                              mac_clr,
    output logic                              busy,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [ACC_WIDTH-1:0]              m_data,
    output logic [idx_width(NUM_MAC)-1:0]     m_idx,
    output logic                              m_last,
    output logic                              done
);

    localparam int IW = idx_width(NUM_MAC);
    localparam int CW = idx_width(SETTLE_CYCLES + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MAC - 1);
    localparam logic [CW-1:0] CNT_LOAD =
        CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    drain_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          done_q, done_d;
    logic          load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // done_q doubles as a one-cycle lockout so start is ignored while done=1
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !done_q) begin
                    if (SETTLE_CYCLES > 0) begin
                        state_d = SETTLE;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = CAPTURE;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            CAPTURE: begin
                load    = 1'b1;
                idx_d   = '0;
                state_d = DRAIN;
            end
            DRAIN: begin
                if (m_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    mac_shadow_bank #(
        .NUM_MAC   (NUM_MAC),
        .ACC_WIDTH (ACC_WIDTH),
        .IW        (IW)
    ) u_bank (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .cout_i (mac_cout),
        .idx_i  (idx_q),
        .data_o (m_data)
    );

    assign mac_clr = (state_q == CAPTURE);
    assign m_valid = (state_q == DRAIN);
    assign busy    = (state_q != IDLE) || done_q;
    assign m_last  = m_valid && (idx_q == LAST_IDX);
    assign m_idx   = idx_q;
    assign done    = done_q;

endmodule
